// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding,
// data widths and the RISC-V NOP used to pad unloaded memory.
package imem_loader_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [STATE_W-1:0] ST_ASSEMBLE = 3'd1;
    localparam logic [STATE_W-1:0] ST_WRITE    = 3'd2;
    localparam logic [STATE_W-1:0] ST_FILL     = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE     = 3'd4;

    // addi x0, x0, 0
    localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0013;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) ();

    logic              byte_valid;
    logic [BYTE_W-1:0] byte_data;
    logic              byte_last;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_wdata;

    modport master (
        output byte_valid, byte_data, byte_last,
        input  byte_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  byte_valid, byte_data, byte_last,
        output byte_ready, imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Collects little-endian bytes into a 32-bit word; clearing zeroes the
// register, so bytes not received before byte_last read as 8'h00.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic [BYTE_W-1:0] data,
    output logic [WORD_W-1:0] word_c,
    output logic              full_c
);

    logic [1:0]        idx_q;
    logic [WORD_W-1:0] word_q;

    // Clear has priority so the closing byte can be captured and dropped at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            word_q <= '0;
        end else if (clear) begin
            idx_q  <= '0;
            word_q <= '0;
        end else if (push) begin
            idx_q  <= idx_q + 2'd1;
            word_q <= word_c;
        end
    end

    always_comb begin
        word_c = word_q;
        if (push) begin
            word_c[{idx_q, 3'b000} +: BYTE_W] = data;
        end
    end

    assign full_c = push && (idx_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams a program image into instruction memory word by word, pads the
// remainder with FILL_WORD, and holds the CPU in reset until loading is done.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 8,
    parameter int unsigned       NUM_WORDS = 64,
    parameter logic [WORD_W-1:0] FILL_WORD = NOP_WORD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    imem_loader_if.slave      bus,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-2:0] words_loaded
);

    localparam int unsigned IDX_W = $clog2(NUM_WORDS);
    localparam int unsigned WL_W  = ADDR_W - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [IDX_W-1:0]   word_idx_q, word_idx_d, next_idx_c;
    logic               last_q, last_d;
    logic [WL_W-1:0]    wl_d;
    logic               ready_d, we_d, cpu_rst_d, busy_d, done_d;
    logic [ADDR_W-1:0]  addr_d, cur_addr_c, next_addr_c;
    logic [WORD_W-1:0]  wdata_d, word_c;
    logic               accept_c, full_c, pack_clear_c;

    assign accept_c    = bus.byte_valid && bus.byte_ready;
    assign next_idx_c  = word_idx_q + IDX_W'(1);
    assign cur_addr_c  = ADDR_W'({word_idx_q, 2'b00});
    assign next_addr_c = ADDR_W'({next_idx_c, 2'b00});

    byte_packer u_packer (
        .clk    (clk),
        .rst    (rst),
        .clear  (pack_clear_c),
        .push   (accept_c),
        .data   (bus.byte_data),
        .word_c (word_c),
        .full_c (full_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            word_idx_q     <= '0;
            last_q         <= 1'b0;
            words_loaded   <= '0;
            bus.byte_ready <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            cpu_rst        <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            state_q        <= state_d;
            word_idx_q     <= word_idx_d;
            last_q         <= last_d;
            words_loaded   <= wl_d;
            bus.byte_ready <= ready_d;
            bus.imem_we    <= we_d;
            bus.imem_addr  <= addr_d;
            bus.imem_wdata <= wdata_d;
            cpu_rst        <= cpu_rst_d;
            busy           <= busy_d;
            done           <= done_d;
        end
    end

    // Outputs are registered, so each is computed from the state being entered.
    always_comb begin
        state_d      = state_q;
        word_idx_d   = word_idx_q;
        last_d       = last_q;
        wl_d         = words_loaded;
        we_d         = 1'b0;
        addr_d       = bus.imem_addr;
        wdata_d      = bus.imem_wdata;
        pack_clear_c = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_ASSEMBLE;
                    word_idx_d   = '0;
                    last_d       = 1'b0;
                    wl_d         = '0;
                    pack_clear_c = 1'b1;
                end
            end
            ST_ASSEMBLE: begin
                if (accept_c && (full_c || bus.byte_last)) begin
                    state_d      = ST_WRITE;
                    we_d         = 1'b1;
                    addr_d       = cur_addr_c;
                    wdata_d      = word_c;
                    last_d       = bus.byte_last;
                    wl_d         = words_loaded + WL_W'(1);
                    pack_clear_c = 1'b1;
                end
            end
            ST_WRITE, ST_FILL: begin
                if (word_idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else if (last_q) begin
                    state_d    = ST_FILL;
                    word_idx_d = next_idx_c;
                    we_d       = 1'b1;
                    addr_d     = next_addr_c;
                    wdata_d    = FILL_WORD;
                end else begin
                    state_d    = ST_ASSEMBLE;
                    word_idx_d = next_idx_c;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d   = (state_d == ST_ASSEMBLE);
        busy_d    = (state_d == ST_ASSEMBLE) || (state_d == ST_WRITE) || (state_d == ST_FILL);
        done_d    = (state_d == ST_DONE);
        cpu_rst_d = (state_d != ST_DONE);
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random images are
// compared write-by-write against a memory image derived from the byte list.
module tb_imem_loader;

    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned NUM_WORDS = 64;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              cpu_rst, busy, done;
    logic [ADDR_W-2:0] words_loaded;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .NUM_WORDS(NUM_WORDS)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bus          (bus),
        .cpu_rst      (cpu_rst),
        .busy         (busy),
        .done         (done),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  img_q[$];
    bit          img_last;
    logic [31:0] exp_img[NUM_WORDS];
    logic [31:0] mem[NUM_WORDS];
    int          exp_wl;
    int          exp_wr;
    bit          frozen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and score any write visible there.
    task automatic tick();
        @(negedge clk);
        if (bus.imem_we) begin
            if (frozen || exp_wr >= int'(NUM_WORDS)) begin
                check("unexpected_we", 32'(bus.imem_we), 32'd0);
            end else begin
                check("wr_addr", 32'(bus.imem_addr), 32'(exp_wr * 4));
                check("wr_data", bus.imem_wdata, exp_img[exp_wr]);
                mem[bus.imem_addr[ADDR_W-1:2]] = bus.imem_wdata;
                exp_wr++;
            end
        end
    endtask

    // Reference image: bytes packed little-endian, zero-padded, NOP beyond the stream.
    task automatic build_exp();
        int n;
        n = img_q.size();
        for (int w = 0; w < int'(NUM_WORDS); w++) begin
            if (4 * w < n) begin
                exp_img[w] = '0;
                for (int b = 0; b < 4; b++)
                    if (4 * w + b < n) exp_img[w][8*b +: 8] = img_q[4*w+b];
            end else begin
                exp_img[w] = NOP;
            end
        end
        exp_wl = (n + 3) / 4;
        if (exp_wl > int'(NUM_WORDS)) exp_wl = NUM_WORDS;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
        check({tag, "_we"},    32'(bus.imem_we),    32'd0);
        check({tag, "_addr"},  32'(bus.imem_addr),  32'd0);
        check({tag, "_wdata"}, bus.imem_wdata,      32'd0);
        check({tag, "_cpurst"}, 32'(cpu_rst),       32'd1);
        check({tag, "_busy"},  32'(busy),           32'd0);
        check({tag, "_done"},  32'(done),           32'd0);
        check({tag, "_wl"},    32'(words_loaded),   32'd0);
    endtask

    // mode 0: back-to-back, 1: idle cycle before every byte, 2: random gaps.
    // stop_word >= 0 returns as soon as that word has been written.
    task automatic run_load(input int mode, input int spur_at, input int stop_word);
        int n;
        build_exp();
        tick();
        start  = 1'b1;
        frozen = 1'b0;
        exp_wr = 0;
        tick();
        start = 1'b0;
        check("start_cpurst", 32'(cpu_rst), 32'd1);
        check("start_busy",   32'(busy),    32'd1);
        check("start_done",   32'(done),    32'd0);
        check("start_wl",     32'(words_loaded), 32'd0);

        for (int i = 0; i < img_q.size(); i++) begin
            tick();
            start = 1'b0;
            if (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0)) begin
                bus.byte_valid = 1'b0;
                tick();
            end
            bus.byte_valid = 1'b1;
            bus.byte_data  = img_q[i];
            bus.byte_last  = img_last && (i == img_q.size() - 1);
            if (i == spur_at) start = 1'b1;
            n = 0;
            while (!bus.byte_ready && n < 64) begin
                tick();
                start = 1'b0;
                n++;
            end
            if (n == 64) begin
                check("hs_timeout", 32'(bus.byte_ready), 32'd1);
                bus.byte_valid = 1'b0;
                return;
            end
        end
        tick();
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;
        start          = 1'b0;

        n = 0;
        while (n < 200) begin
            if (stop_word >= 0 ? (exp_wr > stop_word) : (done == 1'b1)) break;
            tick();
            n++;
        end
        if (stop_word >= 0) begin
            check("reach_word", 32'(exp_wr > stop_word), 32'd1);
        end else begin
            check("done",      32'(done),         32'd1);
            check("end_cpurst", 32'(cpu_rst),     32'd0);
            check("end_busy",  32'(busy),         32'd0);
            check("end_wl",    32'(words_loaded), 32'(exp_wl));
            check("n_writes",  32'(exp_wr),       32'(NUM_WORDS));
        end
    endtask

    task automatic set_ramp();
        img_q.delete();
        for (int i = 0; i < 256; i++) img_q.push_back(8'(i));
        img_last = 1'b0;
    endtask

    task automatic set_random(input int len);
        img_q.delete();
        for (int i = 0; i < len; i++) img_q.push_back(8'($urandom));
        img_last = 1'b1;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;
        bus.byte_last  = 1'b0;
        frozen         = 1'b1;
        exp_wr         = 0;
        repeat (3) tick();
        reset_checks("rst");
        rst = 1'b0;
        repeat (2) tick();
        check("idle_cpurst", 32'(cpu_rst), 32'd1);

        // Full ramp image, then extra bytes that must be refused
        set_ramp();
        run_load(0, -1, -1);
        check("full_w0",  mem[0],  32'h0302_0100);
        check("full_w63", mem[63], 32'hFFFE_FDFC);
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hAA;
        repeat (4) begin
            tick();
            check("ready_after_full", 32'(bus.byte_ready), 32'd0);
        end
        bus.byte_valid = 1'b0;
        check("wl_after_full", 32'(words_loaded), 32'd64);

        // Short image padded with NOPs
        img_q    = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
        img_last = 1'b1;
        run_load(0, -1, -1);
        check("short_w0",  mem[0],  32'h0000_0013);
        check("short_w1",  mem[1],  32'h0000_0093);
        check("short_w2",  mem[2],  32'h0000_0013);
        check("short_w63", mem[63], 32'h0000_0013);

        // Throttled ramp must give the same image
        set_ramp();
        run_load(1, -1, -1);
        check("bp_w63", mem[63], 32'hFFFE_FDFC);

        // Start pulse during a load is ignored
        set_random(41);
        run_load(0, 10, -1);

        // Image ending exactly at the last word goes straight to DONE
        set_random(256);
        run_load(2, -1, -1);

        // Reset in the middle of FILL
        set_random(9);
        run_load(0, -1, 20);
        #1 rst = 1'b1;
        frozen = 1'b1;
        #1 reset_checks("midrst");
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_done", 32'(done), 32'd0);
        set_ramp();
        run_load(0, -1, -1);

        // Random lengths and pacing
        for (int k = 0; k < 4; k++) begin
            set_random(int'($urandom_range(1, 256)));
            run_load(int'($urandom_range(0, 2)), -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: ADDR_W, default 8, byte-address width of instruction memory (256 B).
REQ-002 Parameter: NUM_WORDS, default 64, words per image (2**ADDR_W / 4).
REQ-003 Parameter: FILL_WORD, default 32'h0000_0013, NOP written to unloaded words.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse; begins a load, honoured only in IDLE or DONE.
REQ-007 byte_valid  input  1  source has a byte.
REQ-008 byte_data  input  8  program byte, little-endian order within each word.
REQ-009 byte_last  input  1  qualifies byte_data as the final image byte.
REQ-010 byte_ready  output  1  loader accepts byte this cycle.
REQ-011 imem_we  output  1  instruction-memory write strobe.
REQ-012 imem_addr  output  ADDR_W  byte address, always word-aligned.
REQ-013 imem_wdata  output  32  word to write.
REQ-014 cpu_rst  output  1  active-high hold on the CPU, high while not DONE.
REQ-015 busy  output  1  high in ASSEMBLE, WRITE and FILL.
REQ-016 done  output  1  high in DONE.
REQ-017 words_loaded  output  ADDR_W-1  count of words written from the byte stream, excluding fill.

Function
REQ-018 FSM states: IDLE, ASSEMBLE, WRITE, FILL, DONE.
REQ-019 A byte transfers only on a cycle with byte_valid and byte_ready both high; byte_ready is high only in ASSEMBLE.
REQ-020 IDLE/DONE + start -> ASSEMBLE. This transition clears the byte index, word index and words_loaded, and sets cpu_rst high.
REQ-021 ASSEMBLE: the k-th accepted byte (k=0..3) goes to bits [8k+7:8k]; on the 4th byte, or on any byte with byte_last, go to WRITE on the next cycle.
REQ-022 A partial word ended by byte_last has its unreceived upper bytes set to 8'h00.
REQ-023 WRITE lasts exactly one cycle: imem_we=1, imem_addr=word_idx*4, imem_wdata=assembled word; words_loaded increments.
REQ-024 After WRITE: if word_idx==NUM_WORDS-1 -> DONE. Else if byte_last was seen -> FILL with word_idx+1. Else -> ASSEMBLE with word_idx+1 and the byte index cleared.
REQ-025 FILL writes FILL_WORD to each remaining address, one word per cycle (imem_we=1), and goes to DONE after the write to word NUM_WORDS-1.
REQ-026 Bytes offered after the image is full are not accepted; byte_last on the final byte of word NUM_WORDS-1 leads directly to DONE with no FILL.
REQ-027 DONE: cpu_rst=0 and done=1 until the next start or rst.
REQ-028 start in ASSEMBLE, WRITE or FILL is ignored; the load continues unchanged.
REQ-029 In DONE, start re-enters ASSEMBLE and sets cpu_rst=1 on the same edge.
REQ-030 imem_we is 0 in IDLE, ASSEMBLE and DONE; imem_addr and imem_wdata are don't-care when imem_we=0.
REQ-031 The word index wraps never; it saturates at NUM_WORDS-1 by construction.

Reset
REQ-032 rst asynchronously forces IDLE and these values: byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, busy=0, done=0, words_loaded=0.
REQ-033 rst mid-load abandons the image with no further writes; memory contents are left as they are.

Structure
REQ-034 The state enum and FILL_WORD default (RISC-V NOP 32'h0000_0013) live in the shared CPU package.
REQ-035 A single sub-module, byte_packer (byte index plus 32-bit shift/assemble register with zero-pad), is instantiated; the FSM and address counter stay in imem_loader.

Verification
REQ-036 The bench covers the following directed scenarios.
- Full image: start, then 256 bytes 00..FF streamed back-to-back -> 64 writes, word 0 = 0x03020100 at addr 0x00, word 63 = 0xFFFEFDFC at addr 0xFC, no FILL, done=1, cpu_rst=0.
- Short image: 6 bytes 13 00 00 00 93 00, byte_last on the 6th -> addr 0 = 0x00000013, addr 4 = 0x00000093, addrs 8..FC = 0x00000013, words_loaded=2.
- Backpressure: byte_valid toggled every other cycle -> same memory image as the unthrottled case; no byte lost or duplicated.
- Spurious start mid-load after 10 bytes -> ignored; the image completes identically.
- rst asserted during FILL at word 20 -> outputs return to reset values immediately; next start reloads from addr 0.
- Reload from DONE: start -> cpu_rst rises on the same edge, busy=1, words_loaded=0.
